// File: rtl/video_stream_source.sv
// Synthetic video frame source: blanking-separated frames of ramp / maze-cross / constant content
// with data_ready back-pressure. Optional frame stamp in the top-left 8x8 block: VIDEO_SRC_FRAME_STAMP_EN.
module video_stream_source #(
   parameter int H_ACTIVE = 702,
   parameter int V_ACTIVE = 288,
   parameter int H_BLANK  = 20,
   parameter int V_BLANK  = 4,
   parameter int CORR_X   = 340,
   parameter int CORR_Y   = 140,
   parameter int CORR_W   = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [1:0]  mode,
   input  logic [7:0]  ext_pixel,
   input  logic        video_data_ready,
   output logic        video_frame_valid,
   output logic        video_line_valid,
   output logic        video_data_valid,
   output logic [7:0]  video_data_out,
   output logic [19:0] video_address,
   output logic        frame_done
);

   localparam int VB_CYC = V_BLANK * (H_ACTIVE + 2 * H_BLANK);
   localparam int CNT_W  = $clog2(VB_CYC + H_BLANK + 1);

   localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'(H_BLANK - 1);
   localparam logic [CNT_W-1:0] VB_LAST  = CNT_W'(VB_CYC - 1);
   localparam logic [9:0]       COL_LAST = 10'(H_ACTIVE - 1);
   localparam logic [8:0]       ROW_LAST = 9'(V_ACTIVE - 1);
   localparam logic [9:0]       CX       = 10'(CORR_X);
   localparam logic [9:0]       CY       = 10'(CORR_Y);
   localparam logic [9:0]       CWID     = 10'(CORR_W);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_PRE    = 3'd1;
   localparam logic [2:0] S_ACTIVE = 3'd2;
   localparam logic [2:0] S_HBLANK = 3'd3;
   localparam logic [2:0] S_VBLANK = 3'd4;

   logic [2:0]       state, nstate;
   logic [CNT_W-1:0] cnt, ncnt;
   logic [8:0]       row, nrow;
   logic [9:0]       col, ncol;
   logic [1:0]       mode_r;
   logic [7:0]       ext_r;
   logic             relatch;
   logic             active_n;
   logic [7:0]       pix_n;

   // Maze distances use 10-bit wrap so columns/rows left of the corridor compare as large.
   function automatic logic [7:0] pattern_pixel(input logic [1:0] m, input logic [8:0] r,
                                                input logic [9:0] c, input logic [7:0] lvl);
      logic [9:0] dc;
      logic [9:0] dr;
      logic [7:0] pix;
      dc = c - CX;
      dr = {1'b0, r} - CY;
      case (m)
         2'b00:   pix = c[7:0];
         2'b01:   pix = r[7:0];
         2'b10:   pix = (dc < CWID || dr < CWID) ? 8'hFF : 8'h00;
         default: pix = lvl;
      endcase
      return pix;
   endfunction

   always_comb begin
      nstate  = state;
      ncnt    = cnt;
      nrow    = row;
      ncol    = col;
      relatch = 1'b0;
      case (state)
         S_IDLE: begin
            if (enable) begin
               nstate  = S_PRE;
               ncnt    = '0;
               nrow    = '0;
               ncol    = '0;
               relatch = 1'b1;
            end
         end
         S_PRE: begin
            if (cnt == HB_LAST) begin
               nstate = S_ACTIVE;
               ncol   = '0;
            end else begin
               ncnt = cnt + 1'b1;
            end
         end
         S_ACTIVE: begin
            if (video_data_ready) begin
               if (col == COL_LAST) begin
                  nstate = S_HBLANK;
                  ncnt   = '0;
               end else begin
                  ncol = col + 10'd1;
               end
            end
         end
         S_HBLANK: begin
            if (cnt == HB_LAST) begin
               ncnt = '0;
               ncol = '0;
               if (row == ROW_LAST) begin
                  nstate = S_VBLANK;
               end else begin
                  nstate = S_ACTIVE;
                  nrow   = row + 9'd1;
               end
            end else begin
               ncnt = cnt + 1'b1;
            end
         end
         S_VBLANK: begin
            if (cnt == VB_LAST) begin
               ncnt = '0;
               if (enable) begin
                  nstate  = S_PRE;
                  nrow    = '0;
                  ncol    = '0;
                  relatch = 1'b1;
               end else begin
                  nstate = S_IDLE;
               end
            end else begin
               ncnt = cnt + 1'b1;
            end
         end
         default: nstate = S_IDLE;
      endcase
   end

   assign active_n = (nstate == S_ACTIVE);

`ifdef VIDEO_SRC_FRAME_STAMP_EN
   logic [9:0] frame_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt <= '0;
      end else if (state == S_HBLANK && nstate == S_VBLANK) begin
         frame_cnt <= frame_cnt + 10'd1;
      end
   end

   always_comb begin
      pix_n = pattern_pixel(mode_r, nrow, ncol, ext_r);
      if (nrow < 9'd8 && ncol < 10'd8) begin
         pix_n = frame_cnt[7:0];
      end
   end
`else
   always_comb begin
      pix_n = pattern_pixel(mode_r, nrow, ncol, ext_r);
   end
`endif

   // Pattern selection is frozen for the whole frame.
   always_ff @(posedge clk) begin
      if (relatch) begin
         mode_r <= mode;
         ext_r  <= ext_pixel;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= S_IDLE;
         cnt               <= '0;
         row               <= '0;
         col               <= '0;
         video_frame_valid <= 1'b0;
         video_line_valid  <= 1'b0;
         video_data_valid  <= 1'b0;
         video_data_out    <= 8'h00;
         video_address     <= 20'h0_0000;
         frame_done        <= 1'b0;
      end else begin
         state             <= nstate;
         cnt               <= ncnt;
         row               <= nrow;
         col               <= ncol;
         video_frame_valid <= (nstate == S_PRE) || (nstate == S_ACTIVE) || (nstate == S_HBLANK);
         video_line_valid  <= active_n;
         video_data_valid  <= active_n;
         video_data_out    <= active_n ? pix_n : 8'h00;
         video_address     <= active_n ? {nrow, 1'b0, ncol} : 20'h0_0000;
         frame_done        <= (state == S_HBLANK) && (nstate == S_VBLANK);
      end
   end

endmodule
